rx_irq_coalesce: RTL and testbench

RX_IRQ_COALESCE -- requirements
Module: rx_irq_coalesce

---
 rtl/rx_irq_coalesce.sv | 161 ++++++++++++++++
 tb/tb_rx_irq_coalesce.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_irq_coalesce.sv
// Per-channel RX interrupt coalescing: packet-count / timeout arming, holdoff after
// each acknowledged interrupt, and a round-robin arbiter driving one held request line.
module rx_irq_coalesce #(
    parameter int NCH = 2,
    parameter int CW  = 8,
    parameter int TW  = 16,
    parameter int VW  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] cfg_irq_en,
    input  logic [CW-1:0]  cfg_pkt_thresh,
    input  logic [TW-1:0]  cfg_timeout,
    input  logic [TW-1:0]  cfg_holdoff,
    input  logic [NCH-1:0] pkt_evt,
    input  logic [NCH-1:0] pending,
    output logic           irq_req,
    output logic [VW-1:0]  irq_vec,
    input  logic           irq_ack,
    output logic [31:0]    irq_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FIRE,
        ST_HOLDOFF
    } ch_state_e;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0] TMR_MAX = '1;

    ch_state_e       state_q [NCH];
    ch_state_e       state_d [NCH];
    logic [CW-1:0]   cnt_q   [NCH];
    logic [CW-1:0]   cnt_d   [NCH];
    logic [CW-1:0]   cnt_sat [NCH];
    logic [TW-1:0]   tmr_q   [NCH];
    logic [TW-1:0]   tmr_d   [NCH];

    logic [CW-1:0]   thresh_eff;
    logic            ack_take;
    logic [NCH-1:0]  fire_vec;
    logic            grant_valid;
    logic [VW-1:0]   grant_idx;
    logic [VW-1:0]   rr_ptr;

    assign thresh_eff = (cfg_pkt_thresh == '0) ? CW'(1) : cfg_pkt_thresh;
    // An ack only counts while a request is actually outstanding.
    assign ack_take   = irq_ack & irq_req;

    // Per-channel next-state logic.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
            state_d[ch]  = state_q[ch];
            cnt_d[ch]    = cnt_q[ch];
            tmr_d[ch]    = tmr_q[ch];
            cnt_sat[ch]  = (pkt_evt[ch] && cnt_q[ch] != CNT_MAX) ? cnt_q[ch] + CW'(1) : cnt_q[ch];
            fire_vec[ch] = (state_q[ch] == ST_FIRE) && cfg_irq_en[ch];

            if (!cfg_irq_en[ch]) begin
                state_d[ch] = ST_IDLE;
                cnt_d[ch]   = '0;
                tmr_d[ch]   = '0;
            end else begin
                case (state_q[ch])
                    ST_IDLE: begin
                        if (pkt_evt[ch]) begin
                            state_d[ch] = ST_ARMED;
                            cnt_d[ch]   = CW'(1);
                            tmr_d[ch]   = '0;
                        end
                    end
                    ST_ARMED: begin
                        cnt_d[ch] = cnt_sat[ch];
                        if (tmr_q[ch] != TMR_MAX) tmr_d[ch] = tmr_q[ch] + TW'(1);
                        if (cnt_q[ch] >= thresh_eff || tmr_q[ch] >= cfg_timeout)
                            state_d[ch] = ST_FIRE;
                    end
                    ST_FIRE: begin
                        if (ack_take && irq_vec == VW'(ch)) begin
                            state_d[ch] = ST_HOLDOFF;
                            cnt_d[ch]   = '0;
                            tmr_d[ch]   = cfg_holdoff;
                        end
                    end
                    ST_HOLDOFF: begin
                        cnt_d[ch] = cnt_sat[ch];
                        if (tmr_q[ch] == '0) begin
                            // Packets that landed during holdoff, or unread data, re-arm at once.
                            if (cnt_sat[ch] != '0 || pending[ch]) begin
                                state_d[ch] = ST_ARMED;
                            end else begin
                                state_d[ch] = ST_IDLE;
                                cnt_d[ch]   = '0;
                            end
                            tmr_d[ch] = '0;
                        end else begin
                            tmr_d[ch] = tmr_q[ch] - TW'(1);
                        end
                    end
                    default: state_d[ch] = ST_IDLE;
                endcase
            end
        end
    end

    // Round-robin pick: channels above the last grant first, then wrap from 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!grant_valid && fire_vec[ch] && VW'(ch) > rr_ptr) begin
                grant_valid = 1'b1;
                grant_idx   = VW'(ch);
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (!grant_valid && fire_vec[ch] && VW'(ch) <= rr_ptr) begin
                grant_valid = 1'b1;
                grant_idx   = VW'(ch);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are control state, not storage, so every entry is reset.
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= '0;
                tmr_q[ch]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                tmr_q[ch]   <= tmr_d[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req <= 1'b0;
            irq_vec <= '0;
            irq_cnt <= '0;
            rr_ptr  <= VW'(NCH - 1);
        end else if (ack_take) begin
            irq_req <= 1'b0;
            irq_cnt <= irq_cnt + 32'd1;
        end else if (!irq_req && grant_valid) begin
            irq_req <= 1'b1;
            irq_vec <= grant_idx;
            rr_ptr  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_rx_irq_coalesce.sv
// Directed bench for rx_irq_coalesce: threshold, timeout, round-robin, holdoff,
// disable and mid-request reset scenarios with hand-computed latencies.
module tb_rx_irq_coalesce;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int TW  = 16;
    localparam int VW  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] cfg_irq_en = 2'b11;
    logic [CW-1:0]  cfg_pkt_thresh = 8'd4;
    logic [TW-1:0]  cfg_timeout = 16'd1000;
    logic [TW-1:0]  cfg_holdoff = 16'd0;
    logic [NCH-1:0] pkt_evt = '0;
    logic [NCH-1:0] pending = '0;
    logic           irq_req;
    logic [VW-1:0]  irq_vec;
    logic           irq_ack = 1'b0;
    logic [31:0]    irq_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    rx_irq_coalesce #(.NCH(NCH), .CW(CW), .TW(TW), .VW(VW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_irq_en     (cfg_irq_en),
        .cfg_pkt_thresh (cfg_pkt_thresh),
        .cfg_timeout    (cfg_timeout),
        .cfg_holdoff    (cfg_holdoff),
        .pkt_evt        (pkt_evt),
        .pending        (pending),
        .irq_req        (irq_req),
        .irq_vec        (irq_vec),
        .irq_ack        (irq_ack),
        .irq_cnt        (irq_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NCH-1:0] mask);
        pkt_evt = mask;
        tick();
        pkt_evt = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            tick();
            n++;
            if (irq_req === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vec_cnt++;
        if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", irq_req); end
        vec_cnt++;
        if (irq_vec !== 3'd0) begin err_cnt++; $display("FAIL reset_vec: got %0d want 0", irq_vec); end
        vec_cnt++;
        if (irq_cnt !== 32'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d want 0", irq_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_threshold();
        cfg_pkt_thresh = 8'd4;
        cfg_timeout    = 16'd1000;
        for (int i = 0; i < 3; i++) begin
            pulse(2'b01);
            tick();
        end
        pulse(2'b01);
        vec_cnt++;
        if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL thr_early0: got %b want 0", irq_req); end
        tick();
        vec_cnt++;
        if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL thr_early1: got %b want 0", irq_req); end
        tick();
        vec_cnt++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL thr_fire: got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec);
        end
        repeat (3) tick();
        vec_cnt++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL thr_hold: got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec);
        end
        do_ack();
        exp_cnt++;
        vec_cnt++;
        if (irq_req !== 1'b0 || irq_cnt !== 32'(exp_cnt)) begin
            err_cnt++; $display("FAIL thr_ack: got req=%b cnt=%0d want req=0 cnt=%0d", irq_req, irq_cnt, exp_cnt);
        end
        do_ack();
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt)) begin
            err_cnt++; $display("FAIL stray_ack: got cnt=%0d want %0d", irq_cnt, exp_cnt);
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd8;
        cfg_timeout    = 16'd20;
        pulse(2'b10);
        wait_req(40, n, seen);
        vec_cnt++;
        if (!seen || n < 21 || n > 22) begin
            err_cnt++; $display("FAIL tmo_latency: got seen=%0d cycles=%0d want 21..22", seen, n);
        end
        vec_cnt++;
        if (irq_vec !== 3'd1) begin err_cnt++; $display("FAIL tmo_vec: got %0d want 1", irq_vec); end
        do_ack();
        exp_cnt++;
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt)) begin err_cnt++; $display("FAIL tmo_cnt: got %0d want %0d", irq_cnt, exp_cnt); end
        repeat (3) tick();
        cfg_timeout = 16'd1000;
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd1;
        for (int rep = 0; rep < 2; rep++) begin
            pulse(2'b11);
            wait_req(10, n, seen);
            vec_cnt++;
            if (!seen || irq_vec !== 3'd0) begin
                err_cnt++; $display("FAIL rr_first%0d: got seen=%0d vec=%0d want vec=0", rep, seen, irq_vec);
            end
            do_ack();
            exp_cnt++;
            tick();
            vec_cnt++;
            if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin
                err_cnt++; $display("FAIL rr_second%0d: got req=%b vec=%0d want req=1 vec=1", rep, irq_req, irq_vec);
            end
            tick();
            do_ack();
            exp_cnt++;
            vec_cnt++;
            if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL rr_drop%0d: got %b want 0", rep, irq_req); end
            repeat (3) tick();
        end
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt)) begin err_cnt++; $display("FAIL rr_cnt: got %0d want %0d", irq_cnt, exp_cnt); end
    endtask

    task automatic test_holdoff();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd1;
        cfg_timeout    = 16'd10;
        cfg_holdoff    = 16'd50;
        pending        = 2'b01;
        pulse(2'b01);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL ho_first: got seen=%0d vec=%0d want vec=0", seen, irq_vec);
        end
        do_ack();
        exp_cnt++;
        // 50 holdoff + 1 rearm + 10 timeout + 1 fire + 1 grant
        wait_req(100, n, seen);
        vec_cnt++;
        if (!seen || n !== 63 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL ho_rearm: got seen=%0d cycles=%0d vec=%0d want cycles=63 vec=0", seen, n, irq_vec);
        end
        pending = 2'b00;
        do_ack();
        exp_cnt++;
        wait_req(120, n, seen);
        vec_cnt++;
        if (seen) begin err_cnt++; $display("FAIL ho_idle: got req after %0d cycles want none", n); end
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt)) begin err_cnt++; $display("FAIL ho_cnt: got %0d want %0d", irq_cnt, exp_cnt); end
        cfg_holdoff = 16'd0;
        cfg_timeout = 16'd1000;
    endtask

    task automatic test_disable();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd1;
        pulse(2'b01);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL dis_fire: got seen=%0d vec=%0d want vec=0", seen, irq_vec);
        end
        cfg_irq_en = 2'b10;
        repeat (3) tick();
        vec_cnt++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL dis_hold: got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec);
        end
        do_ack();
        exp_cnt++;
        vec_cnt++;
        if (irq_req !== 1'b0 || irq_cnt !== 32'(exp_cnt)) begin
            err_cnt++; $display("FAIL dis_ack: got req=%b cnt=%0d want req=0 cnt=%0d", irq_req, irq_cnt, exp_cnt);
        end
        pulse(2'b01);
        wait_req(10, n, seen);
        vec_cnt++;
        if (seen) begin err_cnt++; $display("FAIL dis_evt: got req while disabled want none"); end
        cfg_irq_en = 2'b11;
        wait_req(10, n, seen);
        vec_cnt++;
        if (seen) begin err_cnt++; $display("FAIL dis_idle: got req after re-enable want none"); end
    endtask

    task automatic test_zero_cfg();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd0;
        cfg_timeout    = 16'd1000;
        pulse(2'b10);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || n !== 2 || irq_vec !== 3'd1) begin
            err_cnt++; $display("FAIL thresh0: got seen=%0d cycles=%0d vec=%0d want cycles=2 vec=1", seen, n, irq_vec);
        end
        do_ack();
        exp_cnt++;
        repeat (3) tick();
        cfg_pkt_thresh = 8'd8;
        cfg_timeout    = 16'd0;
        pulse(2'b01);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || n !== 2 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL timeout0: got seen=%0d cycles=%0d vec=%0d want cycles=2 vec=0", seen, n, irq_vec);
        end
        do_ack();
        exp_cnt++;
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt)) begin err_cnt++; $display("FAIL zero_cnt: got %0d want %0d", irq_cnt, exp_cnt); end
        repeat (3) tick();
        cfg_timeout = 16'd1000;
    endtask

    task automatic test_reset_mid_request();
        int  n;
        bit  seen;
        cfg_pkt_thresh = 8'd1;
        pulse(2'b10);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || irq_vec !== 3'd1) begin
            err_cnt++; $display("FAIL rst_pre: got seen=%0d vec=%0d want vec=1", seen, irq_vec);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL rst_async: got %b want 0", irq_req); end
        exp_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if (irq_cnt !== 32'(exp_cnt) || irq_req !== 1'b0) begin
            err_cnt++; $display("FAIL rst_post: got cnt=%0d req=%b want cnt=0 req=0", irq_cnt, irq_req);
        end
        pulse(2'b01);
        wait_req(10, n, seen);
        vec_cnt++;
        if (!seen || n !== 2 || irq_vec !== 3'd0) begin
            err_cnt++; $display("FAIL rst_refire: got seen=%0d cycles=%0d vec=%0d want cycles=2 vec=0", seen, n, irq_vec);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_timeout();
        test_back_to_back();
        test_holdoff();
        test_disable();
        test_zero_cfg();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
